// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Bits needed to index WIDTH bit positions; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell shared by the serial engine
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract engine with start/busy/done handshake
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] sum_q;        // bits already produced, LSB-aligned once complete
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;      // carry into the bit currently on the adder
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             overflow_q;

    logic             load;
    logic             last;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_shift;

    full_adder fa_u (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the top; after WIDTH shifts the word is aligned.
    assign sum_shift = {fa_sum, sum_q};

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the load/last strobes for the datapath.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_BIT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, then one bit per cycle through the shared adder cell.
    // Subtract is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            cnt_q   <= '0;
            carry_q <= sub;
        end else if (state_q == RUN) begin
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            sum_q   <= sum_shift[WIDTH-1:1];
            cnt_q   <= cnt_q + 1'b1;
            carry_q <= fa_carry;
        end
    end

    // Visible results move only when the MSB is processed. During that cycle
    // carry_q holds the carry into the MSB, so overflow needs no extra flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (last) begin
            result_q    <= sum_shift;
            carry_out_q <= fa_carry;
            overflow_q  <= carry_q ^ fa_carry;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed vector bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] res;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[8];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called just after the accepting edge; follows the operation to its done pulse.
    task automatic wait_done(input string tag, input logic [7:0] res,
                             input logic co, input logic ov);
        int         lat;
        int         bcnt;
        int         unstable;
        logic [7:0] prev;
        lat      = -1;
        bcnt     = 0;
        unstable = 0;
        prev     = result;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
            if (result !== prev) unstable++;
        end
        check({tag, " latency"},   lat, WIDTH);
        check({tag, " busy_cyc"},  bcnt, WIDTH);
        check({tag, " stable"},    unstable, 0);
        check({tag, " result"},    {24'd0, result}, {24'd0, res});
        check({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, co});
        check({tag, " overflow"},  {31'd0, overflow}, {31'd0, ov});
        @(negedge clk);
        check({tag, " done_1cyc"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic do_op(input string tag, input vec_t v);
        @(negedge clk);
        op_a  = v.a;
        op_b  = v.b;
        sub   = v.s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag, v.res, v.co, v.ov);
    endtask

    initial begin
        int dpulse;
        vec_t v;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, carry_out, overflow, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start held high; operands change while the first operation runs
        @(negedge clk);
        op_a  = 8'h11;
        op_b  = 8'h22;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        op_a = 8'hAA;
        op_b = 8'h55;
        sub  = 1'b1;
        wait_done("hold1", 8'h33, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("hold2", 8'h55, 1'b1, 1'b1);

        // asynchronous reset while bit 3 is on the adder
        @(negedge clk);
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun rst outputs", {busy, done, carry_out, overflow, result}, 32'd0);
        dpulse = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dpulse++;
            if (i == 3) rst = 1'b0;
        end
        check("midrun rst no done", dpulse, 0);
        v = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
        do_op("after_rst", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
